// File: rtl/kim_clk_pkg.sv
// kim_clk_pkg: shared types and elaboration-time helpers for the KIM-1 clock-enable generator.
//   clk_state_t : RUN / HALT / STEP control states
//   acc_width() : phase accumulator width for a given board clock
//   calc_inc()  : accumulator increment (twice the CPU rate, one tick per phi2 edge)
package kim_clk_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} clk_state_t;

  // One spare bit so acc + inc (both < IN_HZ) never overflows before the wrap test.
  function automatic int unsigned acc_width(input int unsigned in_hz);
    return $clog2(in_hz) + 1;
  endfunction

  function automatic int unsigned calc_inc(input int unsigned out_hz, input int unsigned mul,
                                           input logic turbo);
    return turbo ? 2 * out_hz * mul : 2 * out_hz;
  endfunction

endpackage

// File: rtl/kim_phase_acc.sv
// kim_phase_acc: fractional phase accumulator modulo IN_HZ.
//   clk   board clock
//   reset synchronous, active-high; clears the accumulator
//   en    advance the accumulator by inc this clock
//   clr   force the accumulator to zero (wins over en)
//   inc   phase increment, must not exceed IN_HZ
//   tick  combinational: this clock's advance wraps past IN_HZ
module kim_phase_acc #(
  parameter int unsigned IN_HZ = 66_000_000,
  parameter int unsigned ACC_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(IN_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum   = acc_q + inc;
    tick  = en && (sum >= MODULUS);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = tick ? (sum - MODULUS) : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/kim_clk_gen.sv
// kim_clk_gen: exact-average CPU clock-enable generator for the KIM-1 core.
//   clk          board clock (sole clock)
//   reset        synchronous, active-high
//   run          1 = free-run, 0 = halt at the next cycle boundary
//   step_req     one-clk pulse; starts a step burst while halted
//   step_count   cycles per burst (0 acts as 1)
//   turbo        selects OUT_HZ*TURBO_MUL
//   cpu_ce       one-clk strobe per CPU cycle, coincident with phi2 falling
//   phi2         CPU phase, low at cycle boundaries
//   halted       1 in HALT
//   step_busy    1 in STEP
//   cycle_count  number of cpu_ce pulses, wraps
//   heartbeat    toggles every HB_CYCLES cpu_ce pulses
module kim_clk_gen
  import kim_clk_pkg::*;
#(
  parameter int unsigned IN_HZ     = 66_000_000,
  parameter int unsigned OUT_HZ    = 1_000_000,
  parameter int unsigned TURBO_MUL = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HB_CYCLES = 500_000,
  parameter int unsigned START_RUN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic [7:0]       step_count,
  input  logic             turbo,
  output logic             cpu_ce,
  output logic             phi2,
  output logic             halted,
  output logic             step_busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic             heartbeat
);

  localparam int unsigned ACC_W     = acc_width(IN_HZ);
  localparam int unsigned INC_BASE  = calc_inc(OUT_HZ, TURBO_MUL, 1'b0);
  localparam int unsigned INC_TURBO = calc_inc(OUT_HZ, TURBO_MUL, 1'b1);

  if (INC_TURBO > IN_HZ) begin : g_cfg_check
    $error("kim_clk_gen: 2*OUT_HZ*TURBO_MUL must not exceed IN_HZ");
  end

  clk_state_t       state_q, state_d;
  logic             phi2_q, phi2_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic [7:0]       rem_q, rem_d;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      hb_cnt_q;
  logic             hb_q;
  logic             tick, acc_en, acc_clr;
  logic [ACC_W-1:0] inc;

  assign inc    = turbo ? ACC_W'(INC_TURBO) : ACC_W'(INC_BASE);
  assign acc_en = (state_q != ST_HALT);
  // Clearing on every HALT clock also covers the entry clock; HALT holds acc at zero anyway.
  assign acc_clr = (state_d == ST_HALT);

  kim_phase_acc #(
    .IN_HZ (IN_HZ),
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk   (clk),
    .reset (reset),
    .en    (acc_en),
    .clr   (acc_clr),
    .inc   (inc),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    phi2_d   = phi2_q ^ tick;
    cpu_ce_d = tick & phi2_q;
    unique case (state_q)
      ST_RUN: begin
        // Stop only where phi2 ends low: on the falling tick, or idle-low with no tick.
        if (!run && (cpu_ce_d || (!phi2_q && !tick))) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
          rem_d   = (step_count == 8'd0) ? 8'd1 : step_count;
        end
      end
      ST_STEP: begin
        if (run) begin
          state_d = ST_RUN;
          rem_d   = 8'd0;
        end else if (cpu_ce_d) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_HALT;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= (START_RUN != 0) ? ST_RUN : ST_HALT;
      phi2_q   <= 1'b0;
      cpu_ce_q <= 1'b0;
      rem_q    <= 8'd0;
      count_q  <= '0;
      hb_cnt_q <= 32'd0;
      hb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phi2_q   <= phi2_d;
      cpu_ce_q <= cpu_ce_d;
      rem_q    <= rem_d;
      if (cpu_ce_d) begin
        count_q <= count_q + CNT_W'(1);
        if (hb_cnt_q == HB_CYCLES - 1) begin
          hb_cnt_q <= 32'd0;
          hb_q     <= ~hb_q;
        end else begin
          hb_cnt_q <= hb_cnt_q + 32'd1;
        end
      end
    end
  end

  assign cpu_ce      = cpu_ce_q;
  assign phi2        = phi2_q;
  assign halted      = (state_q == ST_HALT);
  assign step_busy   = (state_q == ST_STEP);
  assign cycle_count = count_q;
  assign heartbeat   = hb_q;

endmodule

// File: tb/tb_kim_clk_gen.sv
// tb_kim_clk_gen: self-checking bench for kim_clk_gen.
// Main instance: 66 MHz board, 1 MHz CPU, turbo x4, heartbeat every 4 pulses.
// Second instance: 10 Hz board, 3 Hz CPU, for the uneven-ratio tick pattern.
module tb_kim_clk_gen;

  localparam longint IN_L  = 66_000_000;
  localparam longint INC_B = 2 * 1_000_000;
  localparam longint INC_T = 2 * 1_000_000 * 4;
  localparam longint HB_L  = 4;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic        clk = 1'b0;
  logic        reset, run, step_req, turbo;
  logic [7:0]  step_count;
  logic        cpu_ce, phi2, halted, step_busy, heartbeat;
  logic [31:0] cycle_count;

  logic        reset2;
  logic        run2 = 1'b1;
  logic        step_req2 = 1'b0;
  logic        turbo2 = 1'b0;
  logic [7:0]  step_count2 = 8'd0;
  logic        cpu_ce2, phi2_2, halted2, step_busy2, heartbeat2;
  logic [7:0]  cycle_count2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: total phase since last clear; ticks = total / IN_L, phi2 = tick parity.
  int     m_state;
  longint m_total;
  longint m_pulses;
  int     m_rem;
  bit     m_ce;

  always #5 clk = ~clk;

  kim_clk_gen #(
    .IN_HZ     (66_000_000),
    .OUT_HZ    (1_000_000),
    .TURBO_MUL (4),
    .CNT_W     (32),
    .HB_CYCLES (4),
    .START_RUN (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step_req    (step_req),
    .step_count  (step_count),
    .turbo       (turbo),
    .cpu_ce      (cpu_ce),
    .phi2        (phi2),
    .halted      (halted),
    .step_busy   (step_busy),
    .cycle_count (cycle_count),
    .heartbeat   (heartbeat)
  );

  kim_clk_gen #(
    .IN_HZ     (10),
    .OUT_HZ    (3),
    .TURBO_MUL (1),
    .CNT_W     (8),
    .HB_CYCLES (500_000),
    .START_RUN (1)
  ) dut2 (
    .clk         (clk),
    .reset       (reset2),
    .run         (run2),
    .step_req    (step_req2),
    .step_count  (step_count2),
    .turbo       (turbo2),
    .cpu_ce      (cpu_ce2),
    .phi2        (phi2_2),
    .halted      (halted2),
    .step_busy   (step_busy2),
    .cycle_count (cycle_count2),
    .heartbeat   (heartbeat2)
  );

  task automatic m_update();
    longint nt;
    bit     ticked, ce, lands_low;
    if (reset) begin
      m_state  = M_RUN;
      m_total  = 0;
      m_pulses = 0;
      m_rem    = 0;
      m_ce     = 1'b0;
    end else begin
      nt = m_total;
      if (m_state != M_HALT) nt = m_total + (turbo ? INC_T : INC_B);
      ticked    = (nt / IN_L) != (m_total / IN_L);
      lands_low = ((nt / IN_L) % 2) == 0;
      ce        = ticked && lands_low;
      case (m_state)
        M_RUN: if (!run && lands_low) m_state = M_HALT;
        M_HALT: begin
          if (run) m_state = M_RUN;
          else if (step_req) begin
            m_state = M_STEP;
            m_rem   = (step_count == 8'd0) ? 1 : int'(step_count);
          end
        end
        default: begin
          if (run) begin
            m_state = M_RUN;
            m_rem   = 0;
          end else if (ce) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_state = M_HALT;
          end
        end
      endcase
      m_total = (m_state == M_HALT) ? 0 : nt;
      m_ce    = ce;
      if (ce) m_pulses = m_pulses + 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; step_req = 1'b0; step_count = 8'd0; turbo = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    n_cmp++; if (cpu_ce !== 1'b0) begin n_err++; $display("FAIL reset cpu_ce: got %b want 0", cpu_ce); end
    n_cmp++; if (phi2 !== 1'b0) begin n_err++; $display("FAIL reset phi2: got %b want 0", phi2); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset halted: got %b want 0", halted); end
    n_cmp++; if (step_busy !== 1'b0) begin n_err++; $display("FAIL reset step_busy: got %b want 0", step_busy); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL reset cycle_count: got %0d want 0", cycle_count); end
    n_cmp++; if (heartbeat !== 1'b0) begin n_err++; $display("FAIL reset heartbeat: got %b want 0", heartbeat); end
  endtask

  // Free run at 1 MHz: tick every 33 clks, pulse every 66, heartbeat flips every 4th pulse.
  task automatic test_run_rate();
    bit ece, ep, eh;
    for (int n = 1; n <= 6600; n++) begin
      cyc();
      ece = (n % 66) == 0;
      ep  = (n % 66) >= 33;
      eh  = ((n / 66) / 4) % 2 == 1;
      n_cmp++; if (cpu_ce !== ece) begin n_err++; $display("FAIL rate cpu_ce clk %0d: got %b want %b", n, cpu_ce, ece); end
      n_cmp++; if (phi2 !== ep) begin n_err++; $display("FAIL rate phi2 clk %0d: got %b want %b", n, phi2, ep); end
      n_cmp++; if (heartbeat !== eh) begin n_err++; $display("FAIL rate heartbeat clk %0d: got %b want %b", n, heartbeat, eh); end
    end
    n_cmp++; if (cycle_count !== 32'd100) begin n_err++; $display("FAIL rate cycle_count: got %0d want 100", cycle_count); end
  endtask

  // 10 Hz board / 3 Hz CPU: pulse when floor(6n/10) steps to an even value.
  task automatic test_small_ratio();
    int  cnt, adj;
    bit  prev, ece;
    reset2 = 1'b1;
    cyc();
    reset2 = 1'b0;
    cnt = 0; adj = 0; prev = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      ece = ((n * 6) / 10 != ((n - 1) * 6) / 10) && (((n * 6) / 10) % 2 == 0);
      n_cmp++; if (cpu_ce2 !== ece) begin n_err++; $display("FAIL small cpu_ce clk %0d: got %b want %b", n, cpu_ce2, ece); end
      if (cpu_ce2 === 1'b1) begin
        cnt++;
        if (prev) adj++;
      end
      prev = (cpu_ce2 === 1'b1);
    end
    n_cmp++; if (cnt != 30) begin n_err++; $display("FAIL small pulse count: got %0d want 30", cnt); end
    n_cmp++; if (adj != 0) begin n_err++; $display("FAIL small adjacent pulses: got %0d want 0", adj); end
    n_cmp++; if (cycle_count2 !== 8'd30) begin n_err++; $display("FAIL small cycle_count: got %0d want 30", cycle_count2); end
  endtask

  task automatic test_halt();
    int ces, extra, hi;
    bit ce_at_halt;
    for (int k = 0; k < 100 && ((m_total / IN_L) % 2) == 0; k++) cyc();
    run = 1'b0;
    ces = 0; ce_at_halt = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (cpu_ce === 1'b1) ces++;
      if (halted === 1'b1) begin
        ce_at_halt = cpu_ce;
        break;
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt reached: got %b want 1", halted); end
    n_cmp++; if (ces != 1) begin n_err++; $display("FAIL halt final pulses: got %0d want 1", ces); end
    n_cmp++; if (ce_at_halt !== 1'b1) begin n_err++; $display("FAIL halt ce on entry: got %b want 1", ce_at_halt); end
    n_cmp++; if (phi2 !== 1'b0) begin n_err++; $display("FAIL halt phi2: got %b want 0", phi2); end
    extra = 0; hi = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (cpu_ce !== 1'b0) extra++;
      if (phi2 !== 1'b0) hi++;
    end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL halt idle pulses: got %0d want 0", extra); end
    n_cmp++; if (hi != 0) begin n_err++; $display("FAIL halt idle phi2 high clks: got %0d want 0", hi); end
  endtask

  task automatic test_step();
    int ces;
    step_count = 8'd3; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    n_cmp++; if (step_busy !== 1'b1) begin n_err++; $display("FAIL step busy: got %b want 1", step_busy); end
    ces = 0;
    for (int k = 0; k < 1000; k++) begin
      step_req = (k == 40);
      cyc();
      if (cpu_ce === 1'b1) ces++;
      if (halted === 1'b1) break;
    end
    step_req = 1'b0;
    n_cmp++; if (ces != 3) begin n_err++; $display("FAIL step burst3 pulses: got %0d want 3", ces); end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL step burst3 halted: got %b want 1", halted); end
    step_count = 8'd0; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    ces = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (cpu_ce === 1'b1) ces++;
      if (halted === 1'b1) break;
    end
    n_cmp++; if (ces != 1) begin n_err++; $display("FAIL step burst0 pulses: got %0d want 1", ces); end
    n_cmp++; if (step_busy !== 1'b0) begin n_err++; $display("FAIL step burst0 busy: got %b want 0", step_busy); end
  endtask

  // Any 33-clk turbo window holds 4 ticks; any 66-clk normal window holds 2.
  task automatic test_turbo();
    int ces, bad, last;
    turbo = 1'b1; run = 1'b1;
    cyc();
    ces = 0; bad = 0; last = -1;
    for (int k = 0; k < 3300; k++) begin
      cyc();
      if (cpu_ce === 1'b1) begin
        ces++;
        if (last >= 0 && (k - last) != 16 && (k - last) != 17) bad++;
        last = k;
      end
    end
    n_cmp++; if (ces != 200) begin n_err++; $display("FAIL turbo pulses: got %0d want 200", ces); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL turbo spacing violations: got %0d want 0", bad); end
    turbo = 1'b0;
    ces = 0;
    for (int k = 0; k < 660; k++) begin
      cyc();
      if (cpu_ce === 1'b1) ces++;
    end
    n_cmp++; if (ces != 10) begin n_err++; $display("FAIL turbo-off pulses: got %0d want 10", ces); end
  endtask

  task automatic test_reset_mid_burst();
    int ces;
    run = 1'b0;
    for (int k = 0; k < 200 && halted !== 1'b1; k++) cyc();
    step_count = 8'd5; step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    ces = 0;
    for (int k = 0; k < 1000 && ces < 3; k++) begin
      cyc();
      if (cpu_ce === 1'b1) ces++;
    end
    n_cmp++; if (step_busy !== 1'b1) begin n_err++; $display("FAIL midburst busy before reset: got %b want 1", step_busy); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_cmp++; if (cpu_ce !== 1'b0) begin n_err++; $display("FAIL midburst cpu_ce: got %b want 0", cpu_ce); end
    n_cmp++; if (phi2 !== 1'b0) begin n_err++; $display("FAIL midburst phi2: got %b want 0", phi2); end
    n_cmp++; if (step_busy !== 1'b0) begin n_err++; $display("FAIL midburst step_busy: got %b want 0", step_busy); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL midburst halted: got %b want 0", halted); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL midburst cycle_count: got %0d want 0", cycle_count); end
    n_cmp++; if (heartbeat !== 1'b0) begin n_err++; $display("FAIL midburst heartbeat: got %b want 0", heartbeat); end
  endtask

  task automatic test_random();
    bit          ep, eh, ehalt, ebusy;
    logic [31:0] ec;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom % 64 == 0) run = ~run;
      step_req   = ($urandom % 16) == 0;
      step_count = 8'($urandom_range(0, 4));
      if ($urandom % 128 == 0) turbo = ~turbo;
      reset      = ($urandom % 1000) == 0;
      cyc();
      ep    = ((m_total / IN_L) % 2) == 1;
      eh    = ((m_pulses / HB_L) % 2) == 1;
      ehalt = (m_state == M_HALT);
      ebusy = (m_state == M_STEP);
      ec    = m_pulses[31:0];
      n_cmp++; if (cpu_ce !== m_ce) begin n_err++; $display("FAIL rnd cpu_ce cyc %0d: got %b want %b", i, cpu_ce, m_ce); end
      n_cmp++; if (phi2 !== ep) begin n_err++; $display("FAIL rnd phi2 cyc %0d: got %b want %b", i, phi2, ep); end
      n_cmp++; if (halted !== ehalt) begin n_err++; $display("FAIL rnd halted cyc %0d: got %b want %b", i, halted, ehalt); end
      n_cmp++; if (step_busy !== ebusy) begin n_err++; $display("FAIL rnd step_busy cyc %0d: got %b want %b", i, step_busy, ebusy); end
      n_cmp++; if (cycle_count !== ec) begin n_err++; $display("FAIL rnd cycle_count cyc %0d: got %0d want %0d", i, cycle_count, ec); end
      n_cmp++; if (heartbeat !== eh) begin n_err++; $display("FAIL rnd heartbeat cyc %0d: got %b want %b", i, heartbeat, eh); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; run = 1'b1; step_req = 1'b0; step_count = 8'd0; turbo = 1'b0;
    m_state = M_RUN; m_total = 0; m_pulses = 0; m_rem = 0; m_ce = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_rate();
    test_small_ratio();
    test_halt();
    test_step();
    test_turbo();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kim_clk_gen.md
Name: kim_clk_gen

Overview:
Parametrised clock-enable generator for the KIM-1 core; replaces fixed integer board dividers with a fractional phase accumulator that produces an exact-average CPU cycle rate from any board oscillator. Outputs a one-clock `cpu_ce` strobe and a `phi2` phase, both in the `clk` domain. Adds run/halt/multi-cycle-step control, a turbo multiplier, a cycle counter and a heartbeat. Instantiated in each board top level between the oscillator and KIM_1.

Parameters:
IN_HZ, 66_000_000, board clock frequency
OUT_HZ, 1_000_000, nominal CPU cycle rate
TURBO_MUL, 4, rate multiplier when turbo=1; 2*OUT_HZ*TURBO_MUL <= IN_HZ is required (elaboration assertion)
CNT_W, 32, cycle_count width
HB_CYCLES, 500_000, cpu_ce pulses per heartbeat toggle
START_RUN, 1, 1 = RUN after reset, 0 = HALT after reset

Ports:
clk  in  1  board clock; sole clock
reset  in  1  synchronous, active-high
run  in  1  level; 1 = free-run, 0 = halt at next cycle boundary
step_req  in  1  one-clk pulse; starts a step burst while halted
step_count  in  8  cycles per burst; 0 is treated as 1
turbo  in  1  selects OUT_HZ*TURBO_MUL
cpu_ce  out  1  one-clk strobe, once per CPU cycle
phi2  out  1  CPU phase, low at cycle boundaries
halted  out  1  1 in HALT
step_busy  out  1  1 in STEP
cycle_count  out  CNT_W  cpu_ce count, wraps
heartbeat  out  1  toggles every HB_CYCLES cpu_ce

Behaviour:
- INC = 2*OUT_HZ (turbo=0) or 2*OUT_HZ*TURBO_MUL (turbo=1). ACC_W = clog2(IN_HZ)+1.
- Active clock (state RUN or STEP): sum = acc + INC.
  - If sum >= IN_HZ: acc <= sum - IN_HZ and tick=1.
  - Otherwise: acc <= sum.
  - Invariant: acc < IN_HZ.
- tick toggles phi2 (all outputs registered).
  - On a tick where phi2 goes 1->0, cpu_ce=1 for exactly that clk.
  - cycle_count increments on that same clk.
  - The heartbeat counter advances on that same clk.
- Average cpu_ce rate is exactly IN_HZ/(2*IN_HZ/INC). Per IN_HZ clocks, exactly INC/2 pulses.
- turbo changes take effect on the next clk. acc is not cleared.
- States:
  - RUN:
    - run=0: go to HALT at the clk that asserts cpu_ce. If phi2 is already 0 with no tick pending, go to HALT immediately.
  - HALT:
    - acc is cleared on entry and frozen; phi2=0, cpu_ce=0.
    - run=1 -> RUN.
    - step_req=1 (with run=0) -> STEP, rem <= max(step_count,1).
  - STEP:
    - rem decrements on each cpu_ce. The clk whose cpu_ce makes rem reach 0 also transitions to HALT.
    - run=1 -> RUN immediately, rem cleared.
    - step_req is ignored while in STEP or RUN.
- Halt always lands on a cycle boundary, so phi2 is never frozen high.
- Reset values:
  - acc=0, phi2=0, cpu_ce=0, cycle_count=0, heartbeat=0, HB counter=0, rem=0.
  - State = RUN if START_RUN else HALT; halted/step_busy reflect that state.
- Reset mid-cycle or mid-burst aborts immediately to the reset values; no partial cpu_ce.
- Simultaneous events: run=1 together with step_req → run wins. A tick coincident with a run 1->0 edge still completes normally.

Decomposition:
- Package kim_clk_pkg holds:
  - state enum clk_state_t {ST_RUN, ST_HALT, ST_STEP};
  - a function acc_width(IN_HZ);
  - an INC computation function.
- Sub-module kim_phase_acc (parameters IN_HZ, ACC_W; ports clk, reset, en, clr, inc, tick) holds the accumulator. The top handles phi2, the FSM and the counters.

Test Plan:
1. IN_HZ=66e6, OUT_HZ=1e6, run=1 → tick every 33 clks, cpu_ce every 66 clks, phi2 high 33/low 33. After 6600 clks, cycle_count=100.
2. IN_HZ=10, OUT_HZ=3 → ticks follow a 5-clk period (ticks at clks 2, 4, 5). Over exactly 100 clks from reset, 30 cpu_ce pulses, none adjacent.
3. run 1->0 while phi2=1 → cpu_ce fires once more, then halted=1, phi2=0. Zero cpu_ce over the next 1000 clks.
4. HALT, step_count=3, step_req pulse → step_busy=1, exactly 3 cpu_ce, then halted=1. step_count=0 → exactly 1 cpu_ce. A second step_req during the burst → ignored.
5. turbo=1 with TURBO_MUL=4, IN_HZ=66e6 → cpu_ce spacing averages 16.5 clks (33 clks per 2 pulses). Toggle back to turbo=0 → 66-clk spacing with no lost or extra pulse.
6. reset asserted mid-burst (rem=2) → next clk all outputs at reset values, state per START_RUN. HB_CYCLES=4 → heartbeat toggles on the 4th and 8th cpu_ce.
